shared_mem_arbiter: RTL

//   N-core round-robin arbiter in front of the single-port shared data memory of the multi-core CPU.

---
 rtl/shared_mem_pkg.sv | 35 +++
 rtl/rr_priority_pick.sv | 29 ++
 rtl/shared_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/shared_mem_pkg.sv
// Shared data-memory arbiter: state type, default widths and the round-robin pick function.
package shared_mem_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int MAX_CORES  = 16;

    // One-hot pick of the first set bit of req at or after ptr, wrapping at n-1 back to 0.
    function automatic logic [MAX_CORES-1:0] rr_pick(
        input logic [MAX_CORES-1:0] req,
        input logic [3:0]           ptr,
        input int                   n
    );
        logic [MAX_CORES-1:0] gnt;
        logic [4:0]           idx;
        logic                 found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_CORES; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= 5'(n)) idx = idx - 5'(n);
            if (i < n && !found && req[idx[3:0]]) begin
                gnt[idx[3:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational N-way rotating priority pick: first requester at or after ptr, one-hot result.
module rr_priority_pick
    import shared_mem_pkg::*;
#(
    parameter int N = 4,
    localparam int PTR_W = $clog2(N)
)(
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [MAX_CORES-1:0] req_ext;
    logic [MAX_CORES-1:0] pick;
    logic [3:0]           ptr_ext;
    logic                 unused_hi;

    always_comb begin
        req_ext             = '0;
        req_ext[N-1:0]      = req;
        ptr_ext             = '0;
        ptr_ext[PTR_W-1:0]  = ptr;
    end

    assign pick      = rr_pick(req_ext, ptr_ext, N);
    assign gnt       = pick[N-1:0];
    assign unused_hi = |(pick >> N);

endmodule

// File: rtl/shared_mem_arbiter.sv
// N-core round-robin arbiter with bus locking in front of the 1-cycle-latency shared data memory.
// Define ARB_CONFLICT_EN to add same-address write-conflict reporting (conflict, conflict_cnt).
//
//   state  | meaning
//   ARB    | round-robin among all requesters starting at rr_ptr
//   LOCKED | only owner may be granted; lock_cnt counts its grants under the lock
module shared_mem_arbiter
    import shared_mem_pkg::*;
#(
    parameter int N_CORES  = 4,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = 8
)(
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_CORES-1:0]          core_req,
    input  logic [N_CORES-1:0]          core_we,
    input  logic [N_CORES-1:0]          core_lock,
    input  logic [N_CORES*ADDR_W-1:0]   core_addr,
    input  logic [N_CORES*DATA_W-1:0]   core_wdata,
    output logic [N_CORES-1:0]          core_gnt,
    output logic [N_CORES-1:0]          core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
`ifdef ARB_CONFLICT_EN
    ,
    output logic                        conflict,
    output logic [15:0]                 conflict_cnt
`endif
);

    localparam int               PTR_W = $clog2(N_CORES);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_CORES - 1);

    arb_state_e         state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   gnt_idx, owner_nxt, rd_core_q;
    logic [7:0]         lock_cnt_q, lock_cnt_d;
    logic               relock_blk_q, relock_blk_d;
    logic               rd_vld_q;
    logic               granted;
    logic [N_CORES-1:0] owner_oh, pick_req, pick_gnt;

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
    end

    // In LOCKED the same picker sees only the owner's request.
    assign pick_req = (state_q == LOCKED) ? (core_req & owner_oh) : core_req;

    rr_priority_pick #(.N(N_CORES)) u_pick (
        .req (pick_req),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt)
    );

    assign core_gnt = reset ? '0 : pick_gnt;
    assign granted  = |core_gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_CORES; i++)
            if (core_gnt[i]) gnt_idx = PTR_W'(i);
    end

    assign mem_en    = granted;
    assign mem_we    = granted & core_we[gnt_idx];
    assign mem_addr  = granted ? core_addr[int'(gnt_idx)*ADDR_W +: ADDR_W] : '0;
    assign mem_wdata = granted ? core_wdata[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
    assign owner_nxt = (owner_q == LAST) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        lock_cnt_d   = lock_cnt_q;
        relock_blk_d = relock_blk_q;
        if (granted)
            rr_ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        case (state_q)
            ARB: begin
                // The blocked core may still be granted, just not locked, until it skips a grant.
                if (granted && core_lock[gnt_idx] && MAX_LOCK > 1 &&
                    !(relock_blk_q && gnt_idx == owner_q)) begin
                    state_d    = LOCKED;
                    owner_d    = gnt_idx;
                    lock_cnt_d = 8'd1;
                end
                if (relock_blk_q && !(granted && gnt_idx == owner_q))
                    relock_blk_d = 1'b0;
            end
            LOCKED: begin
                rr_ptr_d = owner_nxt;
                if (!core_req[owner_q] || !core_lock[owner_q]) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else if ({1'b0, lock_cnt_q} + 9'd1 >= 9'(MAX_LOCK)) begin
                    state_d      = ARB;
                    lock_cnt_d   = '0;
                    relock_blk_d = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + 8'd1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ARB;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            lock_cnt_q   <= '0;
            relock_blk_q <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_core_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            relock_blk_q <= relock_blk_d;
            rd_vld_q     <= granted & ~core_we[gnt_idx];
            rd_core_q    <= gnt_idx;
        end
    end

    always_comb begin
        core_rvalid            = '0;
        core_rvalid[rd_core_q] = rd_vld_q;
    end

    // Memory read data already arrives one cycle after issue, aligned with the registered strobe.
    assign core_rdata = mem_rdata;

`ifdef ARB_CONFLICT_EN
    logic conflict_d;

    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < N_CORES; i++)
            for (int j = i + 1; j < N_CORES; j++)
                if (core_req[i] && core_we[i] && core_req[j] && core_we[j] &&
                    core_addr[i*ADDR_W +: ADDR_W] == core_addr[j*ADDR_W +: ADDR_W])
                    conflict_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            conflict <= conflict_d;
            if (conflict_d && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule
